// File: rtl/thermo_ramp_gen.sv
// thermo_ramp_gen: drives one triangle sweep of thermometer codes into a thermometer encoder.
// A start pulse in idle begins the sweep 0 -> 1..WIDTH ones -> 0. Each code is held for
// STEP_CYCLES clocks, and hold freezes the sweep.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - sweep request, honoured only when idle and not in the done cycle
//   hold  - freezes step timer and code while sweeping
//   a     - thermometer code, LSB-first fill
//   level - number of ones in a
//   busy  - high while rising or falling
//   done  - one-cycle pulse when the sweep returns to zero
module thermo_ramp_gen #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned STEP_CYCLES = 12,
  parameter int unsigned LW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [WIDTH-1:0] a,
  output logic [LW-1:0]    level,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TimerMax = TW'(STEP_CYCLES - 1);
  localparam logic [LW-1:0] LevelMax = LW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StRise, StFall} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [LW-1:0]    level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (timer_q == TimerMax) && !hold;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_d     = a_q;
    level_d = level_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The edge that ends the done cycle must not restart the sweep.
        if (start && !done_q) begin
          state_d = StRise;
          timer_d = '0;
          busy_d  = 1'b1;
        end
      end
      StRise: begin
        if (tick) begin
          timer_d = '0;
          level_d = level_q + LW'(1);
          a_d     = {a_q[WIDTH-2:0], 1'b1};
          if (level_q == LevelMax - LW'(1)) begin
            state_d = StFall;
          end
        end else if (!hold) begin
          timer_d = timer_q + TW'(1);
        end
      end
      StFall: begin
        if (tick) begin
          timer_d = '0;
          level_d = level_q - LW'(1);
          a_d     = a_q >> 1;
          if (level_q == LW'(1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (!hold) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      a_q     <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a     = a_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_thermo_ramp_gen.sv
// Bench for thermo_ramp_gen: instance u0 uses the default (7,12) and instance u1 uses STEP_CYCLES=1.
// The sweep model counts non-held edges since the accepted start. It derives the level from that
// count arithmetically.
module tb_thermo_ramp_gen;
  localparam int W = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
  logic [6:0] a0, a1;
  logic [2:0] lvl0, lvl1;
  logic       busy0, done0, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_total0 = 0;

  thermo_ramp_gen #(.WIDTH(7), .STEP_CYCLES(12), .LW(3)) u0 (
    .clk(clk), .rst(rst), .start(start0), .hold(hold0),
    .a(a0), .level(lvl0), .busy(busy0), .done(done0)
  );

  thermo_ramp_gen #(.WIDTH(7), .STEP_CYCLES(1), .LW(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .a(a1), .level(lvl1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Sweep model: elapsed non-held edges since start, active flag, done pulse.
  int m_e[2]   = '{0, 0};
  bit m_act[2] = '{0, 0};
  bit m_dn[2]  = '{0, 0};

  function automatic int step_of(int i);
    return (i == 0) ? 12 : 1;
  endfunction

  function automatic int exp_level(int i, int e, bit act);
    int n;
    if (!act) return 0;
    n = e / step_of(i);
    return (n <= W) ? n : 2 * W - n;
  endfunction

  function automatic int popcount7(logic [6:0] v);
    int c = 0;
    for (int b = 0; b < 7; b++) c += int'(v[b]);
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_e[i]   <= 0;
        m_act[i] <= 1'b0;
        m_dn[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int e   = m_e[i];
        automatic bit act = m_act[i];
        automatic bit dn  = 1'b0;
        automatic bit s   = (i == 0) ? start0 : start1;
        automatic bit h   = (i == 0) ? hold0 : hold1;
        if (act) begin
          if (!h) e++;
          if (e == 2 * W * step_of(i)) begin
            act = 1'b0;
            dn  = 1'b1;
            e   = 0;
          end
        end else if (s && !m_dn[i]) begin
          act = 1'b1;
          e   = 0;
        end
        m_e[i]   <= e;
        m_act[i] <= act;
        m_dn[i]  <= dn;
      end
    end
  end

  task automatic cmp_inst(input string name, input logic [6:0] a, input logic [2:0] l,
                          input logic b, input logic d, input int i);
    int el;
    logic [6:0] ea;
    el = exp_level(i, m_e[i], m_act[i]);
    ea = 7'((1 << el) - 1);
    n_cmp++;
    if (a !== ea || l !== 3'(el) || b !== m_act[i] || d !== m_dn[i]
        || ((a & (a + 7'd1)) != 7'd0) || popcount7(a) != int'(l)) begin
      n_bad++;
      $display("FAIL %s t=%0t: got a=%b lvl=%0d busy=%b done=%b, want a=%b lvl=%0d busy=%b done=%b",
               name, $time, a, l, b, d, ea, el, m_act[i], m_dn[i]);
    end
  endtask

  always @(negedge clk) begin
    cmp_inst("model_u0", a0, lvl0, busy0, done0, 0);
    cmp_inst("model_u1", a1, lvl1, busy1, done1, 1);
    if (done0 === 1'b1) done_total0++;
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int dsnap;

  initial begin
    #1 rst = 1'b1;
    wait_edges(3);
    rst = 1'b0;
    check("reset_a", int'(a0), 0);
    check("reset_busy", int'(busy0), 0);

    // T2: full sweep, start edge k
    start0 = 1'b1; wait_edges(1); start0 = 1'b0;
    check("t2_busy_k", int'(busy0), 1);
    wait_edges(12);  check("t2_a_k12", int'(a0), 7'h01);
    wait_edges(72);  check("t2_a_k84", int'(a0), 7'h7f);
    check("t2_lvl_k84", int'(lvl0), 7);
    wait_edges(12);  check("t2_a_k96", int'(a0), 7'h3f);
    wait_edges(71);  check("t2_lvl_k167", int'(lvl0), 1);
    check("t2_done_k167", int'(done0), 0);
    wait_edges(1);   check("t2_done_k168", int'(done0), 1);
    check("t2_busy_k168", int'(busy0), 0);
    wait_edges(1);   check("t2_done_k169", int'(done0), 0);

    // T3: hold for 20 edges while a=0000111
    start0 = 1'b1; wait_edges(1); start0 = 1'b0;
    wait_edges(40);  check("t3_a_k40", int'(a0), 7'h07);
    hold0 = 1'b1;
    wait_edges(20);  check("t3_a_held", int'(a0), 7'h07);
    check("t3_lvl_held", int'(lvl0), 3);
    hold0 = 1'b0;
    wait_edges(127); check("t3_done_k187", int'(done0), 0);
    wait_edges(1);   check("t3_done_k188", int'(done0), 1);
    wait_edges(1);

    // T4: starts while busy and on the done cycle are ignored
    dsnap = done_total0;
    start0 = 1'b1; wait_edges(1); start0 = 1'b0;
    wait_edges(62);
    start0 = 1'b1; wait_edges(1); start0 = 1'b0;
    check("t4_lvl_k63", int'(lvl0), 5);
    wait_edges(105); check("t4_done_k168", int'(done0), 1);
    start0 = 1'b1;
    wait_edges(1);   check("t4_busy_doneedge", int'(busy0), 0);
    check("t4_lvl_doneedge", int'(lvl0), 0);
    wait_edges(1);   check("t4_busy_after", int'(busy0), 1);
    start0 = 1'b0;
    check("t4_done_count", done_total0 - dsnap, 1);

    // T1: asynchronous reset mid-rise at level 4
    wait_edges(50);  check("t1_lvl_before", int'(lvl0), 4);
    #3 rst = 1'b1;
    #1;
    check("t1_a", int'(a0), 0);
    check("t1_lvl", int'(lvl0), 0);
    check("t1_busy", int'(busy0), 0);
    check("t1_done", int'(done0), 0);
    wait_edges(2);
    rst = 1'b0;
    wait_edges(3);   check("t1_no_restart", int'(busy0), 0);

    // T5: STEP_CYCLES=1
    start1 = 1'b1; wait_edges(1); start1 = 1'b0;
    wait_edges(1);   check("t5_a_k1", int'(a1), 7'h01);
    wait_edges(6);   check("t5_a_k7", int'(a1), 7'h7f);
    wait_edges(1);   check("t5_a_k8", int'(a1), 7'h3f);
    wait_edges(5);   check("t5_done_k13", int'(done1), 0);
    wait_edges(1);   check("t5_done_k14", int'(done1), 1);
    check("t5_a_k14", int'(a1), 0);
    wait_edges(1);   check("t5_done_k15", int'(done1), 0);

    // start and hold together in idle: start accepted, hold freezes from rise on
    start1 = 1'b1; hold1 = 1'b1;
    wait_edges(1);   start1 = 1'b0;
    check("sh_busy", int'(busy1), 1);
    wait_edges(2);   check("sh_lvl_held", int'(lvl1), 0);
    hold1 = 1'b0;
    wait_edges(1);   check("sh_lvl_rel", int'(lvl1), 1);
    wait_edges(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
